banco_reg_reader: RTL and testbench

- Sequential read-out engine for the 8-entry register bank.
- Drives the bank's output-mux select `SEL` through a programmable address window and samples the 16-bit `R` word at each address.
- Presents each word with its address on a valid/ready handshake and accumulates a running checksum.
- Serves as the read-side counterpart of the write path (X/Y/C operation unit, `w_addr`/`en_addr` decoder) and feeds debug/display logic.

---
 rtl/banco_reg_reader_if.sv | 40 ++++
 rtl/banco_reg_reader.sv | 106 ++++++++++
 tb/tb_banco_reg_reader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banco_reg_reader_if.sv
// Purpose: bundles the read-engine control, bank-select, data and status signals.
// Latency: none, this is wiring only.
// Backpressure: valid/ready pair; the consumer drives ready, the engine drives valid.
//
// Signals:
//   start/first_addr/count - scan request (consumer -> engine)
//   SEL/R                  - bank mux select and the resulting word
//   data_out/addr_out      - captured word and its address
//   valid/ready            - output handshake
//   checksum/busy/done     - scan status
interface banco_reg_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int SUM_W  = 19
);
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] SEL;
    logic [DATA_W-1:0] R;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] addr_out;
    logic              valid;
    logic              ready;
    logic [SUM_W-1:0]  checksum;
    logic              busy;
    logic              done;

    // Engine side.
    modport master (
        input  start, first_addr, count, R, ready,
        output SEL, data_out, addr_out, valid, checksum, busy, done
    );

    // Bank + consumer side.
    modport slave (
        output start, first_addr, count, R, ready,
        input  SEL, data_out, addr_out, valid, checksum, busy, done
    );
endinterface

// File: rtl/banco_reg_reader.sv
// Purpose: walks the 8-entry register bank over a programmable address window, presenting each word with a running checksum.
// Latency: first valid 2 edges after start; 2 cycles per word with ready high; done pulses one cycle after the last transfer.
// Backpressure: holds valid, data_out, addr_out and SEL stable while ready is low, indefinitely.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous active-high reset
//   bus   - banco_reg_reader_if master modport (scan request, bank select/data, handshake, status)
module banco_reg_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int SUM_W  = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    banco_reg_reader_if.master    bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD, DONE} state_t;

    // Remaining-word counter is one bit wider so a full-bank scan (count==0) fits.
    localparam logic [ADDR_W:0]   REM_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] SEL_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [ADDR_W-1:0] sel_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SUM_W-1:0]  sum_q;
    logic [ADDR_W:0]   rem_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W-1:0] sel_d;
    logic [SUM_W-1:0]  sum_d;
    logic [ADDR_W:0]   rem_init_d;
    logic [ADDR_W:0]   rem_dec_d;

    // Select increments modulo bank depth by natural wrap of the ADDR_W-bit adder.
    assign sel_d      = sel_q + SEL_ONE;
    assign sum_d      = sum_q + SUM_W'(bus.R);
    assign rem_init_d = (bus.count == '0) ? REM_FULL : {1'b0, bus.count};
    assign rem_dec_d  = rem_q - REM_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sel_q   <= bus.first_addr;
                        rem_q   <= rem_init_d;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    // R has had a full cycle to follow SEL; capture it now.
                    data_q  <= bus.R;
                    addr_q  <= sel_q;
                    sum_q   <= sum_d;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (bus.ready) begin
                        valid_q <= 1'b0;
                        if (rem_q == REM_ONE) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            sel_q   <= sel_d;
                            rem_q   <= rem_dec_d;
                            state_q <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.SEL      = sel_q;
    assign bus.data_out = data_q;
    assign bus.addr_out = addr_q;
    assign bus.valid    = valid_q;
    assign bus.checksum = sum_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_banco_reg_reader.sv
// Purpose: directed bench for banco_reg_reader with a bank model R = 16'h0101*SEL.
// Latency: drives and samples on the falling edge, one cycle per step.
// Backpressure: ready is driven per scenario to exercise stalls.
module tb_banco_reg_reader;
    logic clk;
    logic reset;

    banco_reg_reader_if #(.DATA_W(16), .ADDR_W(3), .SUM_W(19)) bus ();

    banco_reg_reader #(.DATA_W(16), .ADDR_W(3), .SUM_W(19)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Bank mux model.
    assign bus.R = 16'h0101 * {13'd0, bus.SEL};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [2:0]  cap_addr[$];
    logic [15:0] cap_data[$];
    int          done_cyc;
    int          done_cnt;
    int          first_vld;

    // Issue a start at a falling edge; returns at the falling edge of cycle 1.
    task automatic do_start(input logic [2:0] fa, input logic [2:0] cnt);
        bus.start      = 1'b1;
        bus.first_addr = fa;
        bus.count      = cnt;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    // Record transfers and done pulses for a fixed number of cycles (bounded).
    task automatic capture(input int ncyc);
        cap_addr.delete();
        cap_data.delete();
        done_cyc  = 0;
        done_cnt  = 0;
        first_vld = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (bus.valid && first_vld == 0) first_vld = k;
            if (bus.valid && bus.ready) begin
                cap_addr.push_back(bus.addr_out);
                cap_data.push_back(bus.data_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.SEL !== 3'd0 || bus.data_out !== 16'd0 || bus.addr_out !== 3'd0) begin
            failures++;
            $display("FAIL reset_regs sel=%0d data=%h addr=%0d exp 0/0000/0", bus.SEL, bus.data_out, bus.addr_out);
        end
        checks++;
        if (bus.checksum !== 19'd0) begin
            failures++;
            $display("FAIL reset_checksum got=%h exp=0", bus.checksum);
        end
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags valid=%b busy=%b done=%b exp 000", bus.valid, bus.busy, bus.done);
        end
    endtask

    task automatic test_basic;
        logic [2:0]  ea[3];
        logic [15:0] ed[3];
        ea = '{3'd5, 3'd6, 3'd7};
        ed = '{16'h0505, 16'h0606, 16'h0707};
        bus.ready = 1'b1;
        do_start(3'd5, 3'd3);
        capture(10);
        checks++;
        if (cap_addr.size() != 3) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=3", cap_addr.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= cap_addr.size()) begin
                failures++;
                $display("FAIL basic_word%0d missing", i);
            end else if (cap_addr[i] !== ea[i] || cap_data[i] !== ed[i]) begin
                failures++;
                $display("FAIL basic_word%0d got=(%0d,%h) exp=(%0d,%h)", i, cap_addr[i], cap_data[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (bus.checksum !== 19'h01212) begin
            failures++;
            $display("FAIL basic_checksum got=%h exp=01212", bus.checksum);
        end
        checks++;
        if (done_cyc != 7 || done_cnt != 1) begin
            failures++;
            $display("FAIL basic_done cycle=%0d pulses=%0d exp cycle=7 pulses=1", done_cyc, done_cnt);
        end
        checks++;
        if (first_vld != 2) begin
            failures++;
            $display("FAIL basic_first_valid got=%0d exp=2", first_vld);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_after got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_wrap;
        logic [2:0] ea[4];
        ea = '{3'd6, 3'd7, 3'd0, 3'd1};
        bus.ready = 1'b1;
        do_start(3'd6, 3'd4);
        capture(12);
        checks++;
        if (cap_addr.size() != 4) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=4", cap_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= cap_addr.size()) begin
                failures++;
                $display("FAIL wrap_addr%0d missing", i);
            end else if (cap_addr[i] !== ea[i]) begin
                failures++;
                $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, cap_addr[i], ea[i]);
            end
        end
        checks++;
        if (bus.checksum !== 19'h00E0E) begin
            failures++;
            $display("FAIL wrap_checksum got=%h exp=00e0e", bus.checksum);
        end
        checks++;
        if (done_cyc != 9 || done_cnt != 1) begin
            failures++;
            $display("FAIL wrap_done cycle=%0d pulses=%0d exp cycle=9 pulses=1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_full;
        logic [15:0] ed[8];
        ed = '{16'h0000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707};
        bus.ready = 1'b1;
        do_start(3'd0, 3'd0);
        capture(20);
        checks++;
        if (cap_data.size() != 8) begin
            failures++;
            $display("FAIL full_count got=%0d exp=8", cap_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= cap_data.size()) begin
                failures++;
                $display("FAIL full_word%0d missing", i);
            end else if (cap_data[i] !== ed[i] || cap_addr[i] !== i[2:0]) begin
                failures++;
                $display("FAIL full_word%0d got=(%0d,%h) exp=(%0d,%h)", i, cap_addr[i], cap_data[i], i, ed[i]);
            end
        end
        checks++;
        if (bus.checksum !== 19'h01C1C) begin
            failures++;
            $display("FAIL full_checksum got=%h exp=01c1c", bus.checksum);
        end
        checks++;
        if (done_cyc != 17 || done_cnt != 1) begin
            failures++;
            $display("FAIL full_done cycle=%0d pulses=%0d exp cycle=17 pulses=1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_backpressure;
        bus.ready = 1'b0;
        do_start(3'd2, 3'd2);
        @(negedge clk);                 // cycle 2: first valid
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.valid !== 1'b1 || bus.data_out !== 16'h0202 || bus.SEL !== 3'd2 || bus.addr_out !== 3'd2) begin
                failures++;
                $display("FAIL bp_hold%0d valid=%b data=%h sel=%0d addr=%0d exp 1/0202/2/2",
                         i, bus.valid, bus.data_out, bus.SEL, bus.addr_out);
            end
            @(negedge clk);
        end
        bus.ready = 1'b1;
        @(negedge clk);                 // SETTLE for second word
        checks++;
        if (bus.valid !== 1'b0 || bus.SEL !== 3'd3) begin
            failures++;
            $display("FAIL bp_settle valid=%b sel=%0d exp 0/3", bus.valid, bus.SEL);
        end
        @(negedge clk);                 // HOLD for second word
        checks++;
        if (bus.valid !== 1'b1 || bus.data_out !== 16'h0303 || bus.addr_out !== 3'd3) begin
            failures++;
            $display("FAIL bp_word2 valid=%b data=%h addr=%0d exp 1/0303/3", bus.valid, bus.data_out, bus.addr_out);
        end
        @(negedge clk);                 // DONE
        checks++;
        if (bus.done !== 1'b1 || bus.checksum !== 19'h00505) begin
            failures++;
            $display("FAIL bp_done done=%b checksum=%h exp 1/00505", bus.done, bus.checksum);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle done=%b busy=%b exp 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_start_ignored;
        bus.ready = 1'b0;
        do_start(3'd3, 3'd2);
        @(negedge clk);                 // HOLD, first word valid
        bus.start      = 1'b1;
        bus.first_addr = 3'd0;
        bus.count      = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.valid !== 1'b1 || bus.addr_out !== 3'd3 || bus.SEL !== 3'd3 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL ign_hold valid=%b addr=%0d sel=%0d busy=%b exp 1/3/3/1", bus.valid, bus.addr_out, bus.SEL, bus.busy);
        end
        bus.ready = 1'b1;
        capture(8);
        checks++;
        if (cap_addr.size() != 2 || cap_data.size() != 2) begin
            failures++;
            $display("FAIL ign_count got=%0d exp=2", cap_addr.size());
        end else if (cap_data[1] !== 16'h0404 || cap_addr[1] !== 3'd4) begin
            failures++;
            $display("FAIL ign_word2 got=(%0d,%h) exp=(4,0404)", cap_addr[1], cap_data[1]);
        end
        checks++;
        if (bus.checksum !== 19'h00707 || done_cnt != 1) begin
            failures++;
            $display("FAIL ign_end checksum=%h pulses=%0d exp 00707/1", bus.checksum, done_cnt);
        end
    endtask

    task automatic test_reset_mid;
        bus.ready = 1'b0;
        do_start(3'd4, 3'd3);
        @(negedge clk);                 // HOLD with word 4 valid
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.SEL !== 3'd0 ||
            bus.data_out !== 16'd0 || bus.addr_out !== 3'd0 || bus.checksum !== 19'd0) begin
            failures++;
            $display("FAIL rstmid_outputs valid=%b busy=%b done=%b sel=%0d data=%h addr=%0d sum=%h exp all 0",
                     bus.valid, bus.busy, bus.done, bus.SEL, bus.data_out, bus.addr_out, bus.checksum);
        end
        reset = 1'b0;
        @(negedge clk);
        bus.ready = 1'b1;
        do_start(3'd1, 3'd1);
        capture(6);
        checks++;
        if (cap_data.size() != 1) begin
            failures++;
            $display("FAIL rstmid_count got=%0d exp=1", cap_data.size());
        end else if (cap_data[0] !== 16'h0101 || cap_addr[0] !== 3'd1) begin
            failures++;
            $display("FAIL rstmid_word got=(%0d,%h) exp=(1,0101)", cap_addr[0], cap_data[0]);
        end
        checks++;
        if (bus.checksum !== 19'h00101 || done_cyc != 3) begin
            failures++;
            $display("FAIL rstmid_end checksum=%h done_cycle=%0d exp 00101/3", bus.checksum, done_cyc);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.first_addr = 3'd0;
        bus.count      = 3'd0;
        bus.ready      = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_full();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
